chain_score_issuer: RTL

CHAIN_SCORE_ISSUER -- requirements
Module: chain_score_issuer

---
 rtl/chain_score_issuer_if.sv | 42 ++++
 rtl/chain_score_issuer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/chain_score_issuer_if.sv
// rtl/chain_score_issuer_if.sv - anchor, scorer and result bus of chain_score_issuer
//
// Purpose: bundles every handshake/data signal of chain_score_issuer so the
// design and its environment connect through a single port.
// Signals:
//   chain_clear              clear history/index (honoured only while idle)
//   in_valid/in_ready        new-anchor handshake, in_rx/in_qx/in_w payload
//   riX/riY/qiX/qiY/W        registered pair to the scorer, pair_valid marks it
//   score_in                 scorer result, SCORE_LAT cycles after its pair
//   out_valid/out_ready      result handshake, out_f/out_p/out_idx payload
// Modports: slave = chain_score_issuer, master = the environment driving it.

interface chain_score_issuer_if;
  logic        chain_clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rx;
  logic [31:0] in_qx;
  logic [31:0] in_w;
  logic [31:0] riX;
  logic [31:0] riY;
  logic [31:0] qiX;
  logic [31:0] qiY;
  logic [31:0] W;
  logic        pair_valid;
  logic [31:0] score_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_f;
  logic [4:0]  out_p;
  logic [31:0] out_idx;

  modport slave (
    input  chain_clear, in_valid, in_rx, in_qx, in_w, score_in, out_ready,
    output in_ready, riX, riY, qiX, qiY, W, pair_valid, out_valid, out_f, out_p, out_idx
  );

  modport master (
    output chain_clear, in_valid, in_rx, in_qx, in_w, score_in, out_ready,
    input  in_ready, riX, riY, qiX, qiY, W, pair_valid, out_valid, out_f, out_p, out_idx
  );
endinterface

// File: rtl/chain_score_issuer.sv
// rtl/chain_score_issuer.sv - chaining score issuer over a sliding anchor history
//
// Purpose: for every accepted anchor, issues one (current, predecessor) pair per
// cycle against the newest history entries, reduces the delayed scorer results
// into the best chain score f[i] and its predecessor offset, reports them, then
// pushes the anchor into the history.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    chain_score_issuer_if.slave (anchor in, pair/score, result out)
// Parameters: DEPTH (history entries, <= 31), SCORE_LAT (>= 1), MAX_DIST.

module chain_score_issuer #(
  parameter int DEPTH     = 16,
  parameter int SCORE_LAT = 8,
  parameter int MAX_DIST  = 5000
) (
  input  logic               clk,
  input  logic               reset,
  chain_score_issuer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  // One in-flight pair waiting for its score.
  typedef struct packed {
    logic        v;
    logic        legal;
    logic        last;
    logic [4:0]  k;
    logic [31:0] fj;
  } dly_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt, issue_k, sel_k, eff_cnt, lim;
  logic [31:0] idx;
  logic [31:0] cur_rx, cur_qx, cur_w;
  logic [31:0] best;
  logic [4:0]  bestk;
  logic [31:0] hist_rx [DEPTH];
  logic [31:0] hist_qx [DEPTH];
  logic [31:0] hist_f  [DEPTH];
  dly_t        dly [SCORE_LAT+1];
  logic        accept, load_pair, legal, reduce, last_due, out_fire;
  logic [31:0] sel_rx, sel_qx, sel_w, h_rx, h_qx, h_f, cand;
  logic [AW-1:0] h_sel;

  always_comb begin
    accept   = (state == IDLE) && bus.in_valid;
    // A clear arriving with an anchor takes effect before that anchor is counted.
    eff_cnt  = (state == IDLE && bus.chain_clear) ? 5'd0 : cnt;
    lim      = accept ? eff_cnt : cnt;
    // The first pair is loaded on the accept edge straight from the input bus.
    sel_k    = accept ? 5'd1 : issue_k + 5'd1;
    sel_rx   = accept ? bus.in_rx : cur_rx;
    sel_qx   = accept ? bus.in_qx : cur_qx;
    sel_w    = accept ? bus.in_w  : cur_w;
    load_pair = accept ? (eff_cnt != 5'd0) : (state == ISSUE && issue_k != cnt);
    h_sel    = AW'(sel_k - 5'd1);
    h_rx     = hist_rx[h_sel];
    h_qx     = hist_qx[h_sel];
    h_f      = hist_f[h_sel];
    legal    = (sel_rx > h_rx) && (sel_qx > h_qx) && ((sel_rx - h_rx) <= 32'(MAX_DIST));
    cand     = dly[SCORE_LAT].fj + bus.score_in;
    reduce   = (state == ISSUE || state == DRAIN) && dly[SCORE_LAT].v;
    last_due = reduce && dly[SCORE_LAT].last;
    out_fire = (state == OUT) && bus.out_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = (eff_cnt != 5'd0) ? ISSUE : OUT;
      end
      ISSUE: if (issue_k == cnt) state_nxt = DRAIN;
      DRAIN: if (last_due) state_nxt = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      idx            <= '0;
      issue_k        <= '0;
      cur_rx         <= '0;
      cur_qx         <= '0;
      cur_w          <= '0;
      best           <= '0;
      bestk          <= '0;
      bus.pair_valid <= 1'b0;
      bus.riX        <= '0;
      bus.riY        <= '0;
      bus.qiX        <= '0;
      bus.qiY        <= '0;
      bus.W          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_rx[i] <= '0;
        hist_qx[i] <= '0;
        hist_f[i]  <= '0;
      end
      // Clearing the valid flags makes scores for pre-reset pairs harmless.
      for (int s = 0; s <= SCORE_LAT; s++) dly[s] <= '0;
    end else begin
      bus.pair_valid <= load_pair;
      dly[0] <= '{v: load_pair, legal: legal, last: (sel_k == lim), k: sel_k, fj: h_f};
      for (int s = 1; s <= SCORE_LAT; s++) dly[s] <= dly[s-1];

      if (load_pair) begin
        bus.riX <= sel_rx;
        bus.riY <= h_rx;
        bus.qiX <= sel_qx;
        bus.qiY <= h_qx;
        bus.W   <= sel_w;
        issue_k <= sel_k;
      end

      if (state == IDLE && bus.chain_clear) begin
        cnt <= '0;
        idx <= '0;
      end

      if (accept) begin
        cur_rx <= bus.in_rx;
        cur_qx <= bus.in_qx;
        cur_w  <= bus.in_w;
        best   <= bus.in_w;
        bestk  <= '0;
      end

      // Strict compare: on a tie the earlier (smaller k) candidate stays.
      if (reduce && dly[SCORE_LAT].legal && ($signed(cand) > $signed(best))) begin
        best  <= cand;
        bestk <= dly[SCORE_LAT].k;
      end

      if (out_fire) begin
        hist_rx[0] <= cur_rx;
        hist_qx[0] <= cur_qx;
        hist_f[0]  <= best;
        for (int i = 1; i < DEPTH; i++) begin
          hist_rx[i] <= hist_rx[i-1];
          hist_qx[i] <= hist_qx[i-1];
          hist_f[i]  <= hist_f[i-1];
        end
        idx <= idx + 32'd1;
        if (cnt != 5'(DEPTH)) cnt <= cnt + 5'd1;
      end
    end
  end

  assign bus.out_f   = best;
  assign bus.out_p   = bestk;
  assign bus.out_idx = idx;
endmodule
